// File: rtl/if_stage_pkg.sv
// Shared constants and types for the DonkeyRISC instruction fetch stage.
// Optional BIOS fetch path is enabled by defining FETCH_BIOS_EN.
package if_stage_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned IMEM_AW = 14;
    localparam int unsigned BIOS_AW = 12;

    localparam logic [XLEN-1:0] INST_NOP      = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_RESET_BIOS = 32'h4000_0000;
    localparam logic [XLEN-1:0] PC_RESET_IMEM = 32'h1000_0000;
    localparam logic [3:0]      BIOS_REGION   = 4'h4;

    typedef enum logic [1:0] {
        IF_BOOT = 2'd0,
        IF_RUN  = 2'd1,
        IF_HOLD = 2'd2
    } if_state_e;

    // True when the PC lies in the BIOS address region.
    function automatic logic in_bios_region(input logic [XLEN-1:0] pc);
        return pc[XLEN-1:XLEN-4] == BIOS_REGION;
    endfunction

endpackage

// File: rtl/if_stage_fetch_hold.sv
// Hold register for stalled fetch plus the RUN/HOLD instruction mux.
module if_stage_fetch_hold
    import if_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            capture,
    input  logic            use_hold,
    input  logic [XLEN-1:0] mem_data,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] hold_q;

    // Capture the instruction being presented when a stall begins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= INST_NOP;
        end else if (capture) begin
            hold_q <= mem_data;
        end
    end

    assign data = use_hold ? hold_q : mem_data;

endmodule

// File: rtl/if_stage.sv
// DonkeyRISC instruction fetch stage: PC, boot sequence, stall hold, redirect kill.
// Define FETCH_BIOS_EN to add the BIOS fetch port and region-based source select.
module if_stage
    import if_stage_pkg::*;
#(
`ifdef FETCH_BIOS_EN
    parameter logic [31:0] RESET_PC = PC_RESET_BIOS
`else
    parameter logic [31:0] RESET_PC = PC_RESET_IMEM
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [XLEN-1:0]    redirect_pc_i,
    output logic [IMEM_AW-1:0] imem_addr_o,
    input  logic [XLEN-1:0]    imem_dout_i,
`ifdef FETCH_BIOS_EN
    output logic [BIOS_AW-1:0] bios_addr_o,
    input  logic [XLEN-1:0]    bios_dout_i,
`endif
    output logic [XLEN-1:0]    inst_o,
    output logic [XLEN-1:0]    pc_data_o,
    output logic               inst_valid_o
);

    if_state_e       state_q;
    if_state_e       state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_next;
    logic            capture;
    logic            use_hold;
    logic [XLEN-1:0] mem_data;
    logic [XLEN-1:0] fetched;

    // Next fetch address: redirect beats boot/stall, which beat sequential.
    always_comb begin
        pc_next = pc_q + 32'd4;
        if (redirect_i) begin
            pc_next = redirect_pc_i & ~32'd3;
        end else if (state_q == IF_BOOT || stall_i) begin
            pc_next = pc_q;
        end
    end

    // PC of the data currently returning from memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

    // Fetch state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IF_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and hold-register control.
    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        use_hold = 1'b0;
        case (state_q)
            IF_BOOT: state_d = IF_RUN;
            IF_RUN: begin
                if (stall_i && !redirect_i) begin
                    state_d = IF_HOLD;
                    capture = 1'b1;
                end
            end
            IF_HOLD: begin
                use_hold = 1'b1;
                if (!stall_i || redirect_i) begin
                    state_d = IF_RUN;
                end
            end
            default: state_d = IF_BOOT;
        endcase
    end

    assign imem_addr_o = pc_next[IMEM_AW+1:2];

`ifdef FETCH_BIOS_EN
    logic bios_sel_q;

    assign bios_addr_o = pc_next[BIOS_AW+1:2];

    // Source select tracks the address issued last cycle, matching read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bios_sel_q <= in_bios_region(RESET_PC);
        end else begin
            bios_sel_q <= in_bios_region(pc_next);
        end
    end

    assign mem_data = bios_sel_q ? bios_dout_i : imem_dout_i;
`else
    assign mem_data = imem_dout_i;
`endif

    if_stage_fetch_hold u_fetch_hold (
        .clk      (clk),
        .rst      (rst),
        .capture  (capture),
        .use_hold (use_hold),
        .mem_data (mem_data),
        .data     (fetched)
    );

    // Output select with the redirect kill mask applied on top.
    always_comb begin
        inst_o       = INST_NOP;
        inst_valid_o = 1'b0;
        if (!redirect_i && (state_q == IF_RUN || state_q == IF_HOLD)) begin
            inst_o       = fetched;
            inst_valid_o = 1'b1;
        end
    end

    assign pc_data_o = pc_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: vector table + scoreboard, reset-in-HOLD sequence.
module tb_if_stage;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        wr;
        logic [31:0] inst;
        logic        valid;
        logic [31:0] pc;
        logic [13:0] addr;
    } vec_t;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] RPC  = 32'h4000_0000;
    localparam int          NVEC = 18;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [13:0] imem_addr;
    logic [31:0] imem_dout = '0;
    logic [31:0] inst;
    logic [31:0] pc_data;
    logic        inst_valid;
`ifdef FETCH_BIOS_EN
    logic [11:0] bios_addr;
    logic [31:0] bios_dout = '0;
`endif

    logic [31:0] mem [0:16383];
    vec_t        tv [NVEC];
    vec_t        sb [$];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(RPC)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_addr_o   (imem_addr),
        .imem_dout_i   (imem_dout),
`ifdef FETCH_BIOS_EN
        .bios_addr_o   (bios_addr),
        .bios_dout_i   (bios_dout),
`endif
        .inst_o        (inst),
        .pc_data_o     (pc_data),
        .inst_valid_o  (inst_valid)
    );

    // Synchronous memories: data one cycle after the address.
    always @(posedge clk) begin
        imem_dout <= mem[imem_addr];
`ifdef FETCH_BIOS_EN
        bios_dout <= mem[{2'b00, bios_addr}];
`endif
    end

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rp,
                                input logic w, input logic [31:0] i, input logic v,
                                input logic [31:0] p, input logic [13:0] a);
        vec_t t;
        t.stall = s; t.redir = r; t.rpc = rp; t.wr = w;
        t.inst = i; t.valid = v; t.pc = p; t.addr = a;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pop the oldest expectation and compare it with the live outputs.
    task automatic check_head(input string tag);
        vec_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_sb: got empty scoreboard expected an entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_inst"},  inst, e.inst);
            chk({tag, "_valid"}, 32'(inst_valid), 32'(e.valid));
            chk({tag, "_pc"},    pc_data, e.pc);
            chk({tag, "_addr"},  32'(imem_addr), 32'(e.addr));
        end
    endtask

    // Drive one cycle of stimulus just after posedge, check at negedge.
    task automatic run_vec(input vec_t v, input string tag);
        stall       = v.stall;
        redirect    = v.redir;
        redirect_pc = v.rpc;
        if (v.wr) mem[v.pc[15:2]] = 32'hDEAD_BEEF;
        sb.push_back(v);
        @(negedge clk);
        check_head(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 32'hA000_0000 | 32'(i);
        mem[0] = 32'h0050_0093;

        // Reset release, straight line, 3-cycle stall with store, redirects.
        tv[0]  = mk(0, 0, 32'h0,           0, NOP,           0, 32'h4000_0000, 14'h000);
        tv[1]  = mk(0, 0, 32'h0,           0, 32'h0050_0093, 1, 32'h4000_0000, 14'h001);
        tv[2]  = mk(0, 0, 32'h0,           0, 32'hA000_0001, 1, 32'h4000_0004, 14'h002);
        tv[3]  = mk(1, 0, 32'h0,           0, 32'hA000_0002, 1, 32'h4000_0008, 14'h002);
        tv[4]  = mk(1, 0, 32'h0,           1, 32'hA000_0002, 1, 32'h4000_0008, 14'h002);
        tv[5]  = mk(1, 0, 32'h0,           0, 32'hA000_0002, 1, 32'h4000_0008, 14'h002);
        tv[6]  = mk(0, 0, 32'h0,           0, 32'hA000_0002, 1, 32'h4000_0008, 14'h003);
        tv[7]  = mk(0, 0, 32'h0,           0, 32'hA000_0003, 1, 32'h4000_000C, 14'h004);
        tv[8]  = mk(0, 1, 32'h1000_0022,   0, NOP,           0, 32'h4000_0010, 14'h008);
        tv[9]  = mk(0, 0, 32'h0,           0, 32'hA000_0008, 1, 32'h1000_0020, 14'h009);
        tv[10] = mk(1, 1, 32'h4000_0100,   0, NOP,           0, 32'h1000_0024, 14'h040);
        tv[11] = mk(0, 0, 32'h0,           0, 32'hA000_0040, 1, 32'h4000_0100, 14'h041);
        tv[12] = mk(0, 0, 32'h0,           0, 32'hA000_0041, 1, 32'h4000_0104, 14'h042);
        tv[13] = mk(1, 0, 32'h0,           0, 32'hA000_0042, 1, 32'h4000_0108, 14'h042);
        tv[14] = mk(1, 1, 32'h4000_0201,   0, NOP,           0, 32'h4000_0108, 14'h080);
        tv[15] = mk(0, 0, 32'h0,           0, 32'hA000_0080, 1, 32'h4000_0200, 14'h081);
        tv[16] = mk(1, 0, 32'h0,           0, 32'hA000_0081, 1, 32'h4000_0204, 14'h081);
        tv[17] = mk(1, 0, 32'h0,           0, 32'hA000_0081, 1, 32'h4000_0204, 14'h081);

        // Reset state while rst is held.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_inst",  inst, NOP);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_pc",    pc_data, RPC);
        chk("rst_addr",  32'(imem_addr), 32'(RPC[15:2]));
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) run_vec(tv[i], $sformatf("v%0d", i));

        // Still stalled: in HOLD, then reset asynchronously mid-cycle.
        chk("hold_inst",  inst, 32'hA000_0081);
        chk("hold_valid", 32'(inst_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_inst",  inst, NOP);
        chk("midrst_valid", 32'(inst_valid), 32'd0);
        chk("midrst_pc",    pc_data, RPC);
        chk("midrst_addr",  32'(imem_addr), 32'(RPC[15:2]));
        stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Boot sequence repeats after the second reset.
        for (int i = 0; i < 3; i++) run_vec(tv[i], $sformatf("reboot%0d", i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
